// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   XLEN          - datapath width
//   INSTR_NOP     - ADDI x0,x0,0; driven on dec_instr while nothing is valid
//   PC_STEP       - byte increment between sequential fetches
//   fetch_entry_t - {pc, instr} pair buffered between fetch and decode
package fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} entries for decode.
// Ports:
//   i_clk    - clock; all state changes on the rising edge
//   i_rst_n  - synchronous active-low reset
//   i_push   - write i_wdata at the tail (caller guarantees room, or a same-cycle pop)
//   i_pop    - drop the head (caller guarantees non-empty)
//   i_flush  - discard all entries and reset pointers; overrides push/pop
//   i_wdata  - entry to write
//   o_head   - entry at the head (meaningless while o_empty)
//   o_count  - number of valid entries
//   o_full   - o_count == DEPTH
//   o_empty  - o_count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  entry_t           i_wdata,
  output entry_t           o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count gates visibility of every slot.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CntMax);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the instruction memory
// (combinational read), buffers {pc, instr} in a FIFO and hands entries to
// decode over valid/ready. Redirects reload the PC and flush the FIFO.
// Optional feature macro: FETCH_PERF_EN adds push and stall counters.
// Ports:
//   i_clk, i_rst_n          - clock, synchronous active-low reset
//   i_fetch_en              - allow new fetches
//   i_redirect_valid        - branch/jump taken this cycle (highest priority)
//   i_redirect_target       - new PC; low two bits are dropped
//   o_redirect_misaligned   - registered pulse: last redirect target had [1:0] != 0
//   o_instruction_addr      - byte address to instruction memory (the PC register)
//   i_instruction_read      - instruction word for o_instruction_addr
//   o_dec_valid/i_dec_ready - decode handshake
//   o_dec_instr, o_dec_pc   - head entry (NOP / 0 while not valid)
//   o_perf_fetch_cnt        - pushes since reset (FETCH_PERF_EN only)
//   o_perf_stall_cnt        - cycles blocked by a full FIFO (FETCH_PERF_EN only)
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetch_en,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_redirect_misaligned,
  output logic [31:0] o_instruction_addr,
  input  logic [31:0] i_instruction_read,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_instr,
  output logic [31:0] o_dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      r_pc;
  logic [31:0]      w_pc_next;
  logic             r_misaligned;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_wdata;
  fetch_entry_t     w_head;

  assign w_pop  = o_dec_valid & i_dec_ready;
  // A full FIFO may still accept a push when the head leaves this cycle.
  assign w_push = i_fetch_en & ~i_redirect_valid & (~w_full | w_pop);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = i_instruction_read;

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect_valid) begin
      w_pc_next = {i_redirect_target[31:2], 2'b00};
    end else if (w_push) begin
      w_pc_next = r_pc + PC_STEP;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_VECTOR;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_misaligned <= i_redirect_valid & (i_redirect_target[1:0] != 2'b00);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_instruction_addr    = r_pc;
  assign o_redirect_misaligned = r_misaligned;
  assign o_dec_valid           = ~w_empty;
  assign o_dec_instr           = w_empty ? INSTR_NOP : w_head.instr;
  assign o_dec_pc              = w_empty ? 32'h0 : w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (i_fetch_en && !i_redirect_valid && !w_push) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch;
  assign o_perf_stall_cnt = r_perf_stall;
`endif

  // Count is only needed inside the FIFO; keep the net referenced.
  logic w_unused;
  assign w_unused = ^w_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (RESET_VECTOR = 0x100, DEPTH = 2).
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;
  logic [31:0] instruction_addr;
  logic [31:0] instruction_read;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .RESET_VECTOR (32'h0000_0100),
    .DEPTH        (2)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_fetch_en            (fetch_en),
    .i_redirect_valid      (redirect_valid),
    .i_redirect_target     (redirect_target),
    .o_redirect_misaligned (redirect_misaligned),
    .o_instruction_addr    (instruction_addr),
    .i_instruction_read    (instruction_read),
    .o_dec_valid           (dec_valid),
    .i_dec_ready           (dec_ready),
    .o_dec_instr           (dec_instr),
    .o_dec_pc              (dec_pc)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetch_cnt      (perf_fetch_cnt),
    .o_perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign instruction_read = imem(instruction_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    step(); step();
    checks++; if (dec_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b exp=0", dec_valid); end
    checks++; if (redirect_misaligned !== 1'b0) begin errors++;
      $display("FAIL reset_misaligned got=%b exp=0", redirect_misaligned); end
    checks++; if (instruction_addr !== 32'h100) begin errors++;
      $display("FAIL reset_addr got=%h exp=00000100", instruction_addr); end
    checks++; if (dec_instr !== 32'h13 || dec_pc !== 32'h0) begin errors++;
      $display("FAIL reset_idle_data got=%h/%h exp=00000013/00000000", dec_instr, dec_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (instruction_addr !== 32'h100 + 32'(4 * i)) begin errors++;
        $display("FAIL stream_addr[%0d] got=%h exp=%h", i, instruction_addr,
                 32'h100 + 32'(4 * i)); end
      if (i > 0) begin
        epc = 32'h100 + 32'(4 * (i - 1));
        checks++; if (dec_valid !== 1'b1 || dec_pc !== epc || dec_instr !== imem(epc)) begin
          errors++;
          $display("FAIL stream_dec[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                   i, dec_valid, dec_pc, dec_instr, epc, imem(epc)); end
      end
      step();
    end
    // Drain the one remaining entry (0x10C).
    fetch_en = 1'b0;
    checks++; if (dec_pc !== 32'h10C) begin errors++;
      $display("FAIL stream_tail got=%h exp=0000010c", dec_pc); end
    step();
    checks++; if (dec_valid !== 1'b0) begin errors++;
      $display("FAIL stream_drained got=%b exp=0", dec_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] eaddr;
    fetch_en = 1'b1; dec_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      eaddr = 32'h110 + ((k < 2) ? 32'(4 * k) : 32'd8);
      checks++; if (instruction_addr !== eaddr) begin errors++;
        $display("FAIL bp_addr[%0d] got=%h exp=%h", k, instruction_addr, eaddr); end
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h110 || dec_instr !== imem(32'h110)) begin
        errors++;
        $display("FAIL bp_stable[%0d] got v=%b pc=%h ins=%h exp v=1 pc=00000110 ins=%h",
                 k, dec_valid, dec_pc, dec_instr, imem(32'h110)); end
    end
    fetch_en = 1'b0; dec_ready = 1'b1;
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h114 || dec_instr !== imem(32'h114)) begin
      errors++;
      $display("FAIL bp_drain1 got v=%b pc=%h exp v=1 pc=00000114", dec_valid, dec_pc); end
    step();
    checks++; if (dec_valid !== 1'b0 || instruction_addr !== 32'h118) begin errors++;
      $display("FAIL bp_drain2 got v=%b addr=%h exp v=0 addr=00000118",
               dec_valid, instruction_addr); end
  endtask

  task automatic test_redirect_flush();
    fetch_en = 1'b1; dec_ready = 1'b0;
    step(); step();
    checks++; if (instruction_addr !== 32'h120 || dec_pc !== 32'h118) begin errors++;
      $display("FAIL rd_fill got addr=%h pc=%h exp addr=00000120 pc=00000118",
               instruction_addr, dec_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h200; dec_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    checks++; if (instruction_addr !== 32'h200 || dec_valid !== 1'b0) begin errors++;
      $display("FAIL rd_flush got addr=%h v=%b exp addr=00000200 v=0",
               instruction_addr, dec_valid); end
    checks++; if (redirect_misaligned !== 1'b0) begin errors++;
      $display("FAIL rd_aligned_flag got=%b exp=0", redirect_misaligned); end
    step();
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200 || dec_instr !== imem(32'h200)) begin
      errors++;
      $display("FAIL rd_first got v=%b pc=%h exp v=1 pc=00000200", dec_valid, dec_pc); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step();
    redirect_valid = 1'b0;
    checks++; if (instruction_addr !== 32'h200 || redirect_misaligned !== 1'b1) begin errors++;
      $display("FAIL mis_pulse got addr=%h flag=%b exp addr=00000200 flag=1",
               instruction_addr, redirect_misaligned); end
    step();
    checks++; if (redirect_misaligned !== 1'b0 || dec_pc !== 32'h200) begin errors++;
      $display("FAIL mis_clear got flag=%b pc=%h exp flag=0 pc=00000200",
               redirect_misaligned, dec_pc); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (instruction_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_pre got=%h exp=fffffffc", instruction_addr); end
    step();
    checks++; if (instruction_addr !== 32'h0 || dec_pc !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_post got addr=%h pc=%h exp addr=00000000 pc=fffffffc",
               instruction_addr, dec_pc); end
  endtask

  task automatic test_reset_full();
    dec_ready = 1'b0;
    step(); step(); step();
    checks++; if (instruction_addr !== 32'h4 || dec_pc !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL rf_full got addr=%h pc=%h exp addr=00000004 pc=fffffffc",
               instruction_addr, dec_pc); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd12 || perf_stall_cnt !== 32'd5) begin errors++;
      $display("FAIL perf_pre got fetch=%0d stall=%0d exp fetch=12 stall=5",
               perf_fetch_cnt, perf_stall_cnt); end
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; fetch_en = 1'b0;
    checks++; if (dec_valid !== 1'b0 || instruction_addr !== 32'h100) begin errors++;
      $display("FAIL rf_reset got v=%b addr=%h exp v=0 addr=00000100",
               dec_valid, instruction_addr); end
`ifdef FETCH_PERF_EN
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++;
      $display("FAIL perf_reset got fetch=%0d stall=%0d exp 0/0",
               perf_fetch_cnt, perf_stall_cnt); end
`endif
    step();
    checks++; if (dec_valid !== 1'b0) begin errors++;
      $display("FAIL rf_hold got v=%b exp=0", dec_valid); end
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_misaligned();
    test_wrap();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
